// File: rtl/sram_avalon_ctrl.sv
// Avalon-MM slave front end for an asynchronous SRAM (CE/OE/WE strobes,
// per-byte enables, shared DQ bus) with programmable read and write wait
// states, a write hold cycle and a read-to-write bus turnaround gap.
// Every SRAM pin is driven from a flop, so no avs_* input reaches a pin
// through combinational logic.
module sram_avalon_ctrl #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 1,
    parameter int TURNAROUND = 1
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    input  logic [ADDR_W-1:0]      avs_address,
    input  logic [DATA_W/8-1:0]    avs_byteenable,
    input  logic                   avs_read,
    input  logic                   avs_write,
    input  logic [DATA_W-1:0]      avs_writedata,
    output logic [DATA_W-1:0]      avs_readdata,
    output logic                   avs_readdatavalid,
    output logic                   avs_waitrequest,
    output logic [ADDR_W-1:0]      SRAM_ADDR,
    inout  wire  [DATA_W-1:0]      SRAM_DQ,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_WE_N,
    output logic [DATA_W/8-1:0]    SRAM_BE_N
);

    localparam int NB = DATA_W / 8;

    // Counter preloads: a state lasting N cycles starts its count at N-1.
    localparam logic [3:0] RD_CNT   = 4'(READ_WAIT);
    localparam logic [3:0] WR_CNT   = 4'(WRITE_WAIT);
    localparam logic [3:0] TURN_CNT = 4'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
    localparam bit         USE_TURN = (TURNAROUND > 0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TURN    = 3'd1,
        RD      = 3'd2,
        WR      = 3'd3,
        WR_HOLD = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                last_rd_q, last_rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NB-1:0]       be_n_q, be_n_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic                dq_oe_q, dq_oe_d;
    logic                rdv_q, rdv_d;

    // Next-state and next-pin computation; pins only change on entry to a new phase.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_rd_d = last_rd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        be_n_d    = be_n_q;
        ce_n_d    = ce_n_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        dq_oe_d   = dq_oe_q;
        rdv_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // Write has priority when both requests are raised together.
                if (avs_write) begin
                    addr_d  = avs_address;
                    wdata_d = avs_writedata;
                    be_n_d  = ~avs_byteenable;
                    if (last_rd_q && USE_TURN) begin
                        state_d = TURN;
                        cnt_d   = TURN_CNT;
                    end else begin
                        state_d = WR;
                        cnt_d   = WR_CNT;
                        ce_n_d  = 1'b0;
                        // An all-lanes-off write keeps its timing but never strobes WE.
                        we_n_d  = ~|avs_byteenable;
                        dq_oe_d = 1'b1;
                    end
                end else if (avs_read) begin
                    addr_d  = avs_address;
                    be_n_d  = '0;
                    state_d = RD;
                    cnt_d   = RD_CNT;
                    ce_n_d  = 1'b0;
                    oe_n_d  = 1'b0;
                end
            end
            TURN: begin
                if (cnt_q == 4'd0) begin
                    state_d = WR;
                    cnt_d   = WR_CNT;
                    ce_n_d  = 1'b0;
                    we_n_d  = &be_n_q;
                    dq_oe_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD: begin
                if (cnt_q == 4'd0) begin
                    rdata_d   = SRAM_DQ;
                    rdv_d     = 1'b1;
                    last_rd_d = 1'b1;
                    state_d   = IDLE;
                    ce_n_d    = 1'b1;
                    oe_n_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR: begin
                if (cnt_q == 4'd0) begin
                    state_d = WR_HOLD;
                    we_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_HOLD: begin
                // DQ is released here, so a read may follow with no gap.
                state_d   = IDLE;
                ce_n_d    = 1'b1;
                dq_oe_d   = 1'b0;
                last_rd_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                dq_oe_d = 1'b0;
            end
        endcase
    end

    // State and pin registers; reset forces strobes inactive and DQ released immediately.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            last_rd_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            be_n_q    <= '1;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            dq_oe_q   <= 1'b0;
            rdv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_rd_q <= last_rd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            be_n_q    <= be_n_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            dq_oe_q   <= dq_oe_d;
            rdv_q     <= rdv_d;
        end
    end

    assign avs_waitrequest   = !reset_reset_n || (state_q != IDLE);
    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rdv_q;
    assign SRAM_ADDR         = addr_q;
    assign SRAM_BE_N         = be_n_q;
    assign SRAM_CE_N         = ce_n_q;
    assign SRAM_OE_N         = oe_n_q;
    assign SRAM_WE_N         = we_n_q;
    assign SRAM_DQ           = dq_oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_avalon_ctrl.sv
// Bench for sram_avalon_ctrl: behavioural async SRAM on the pins, a flat
// reference memory plus cycle-count rules for the Avalon side, directed
// waveform sequences, a vector table and a randomized phase.
module tb_sram_avalon_ctrl;

    localparam int AW = 18;
    localparam int DW = 16;
    localparam int RW = 1;
    localparam int WW = 2;
    localparam int TA = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] avs_address;
    logic [1:0]    avs_byteenable;
    logic          avs_read;
    logic          avs_write;
    logic [DW-1:0] avs_writedata;
    logic [DW-1:0] avs_readdata;
    logic          avs_readdatavalid;
    logic          avs_waitrequest;
    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_dq;
    logic          sram_ce_n, sram_oe_n, sram_we_n;
    logic [1:0]    sram_be_n;

    sram_avalon_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .READ_WAIT(RW), .WRITE_WAIT(WW), .TURNAROUND(TA)
    ) dut (
        .clk_clk(clk),
        .reset_reset_n(rst_n),
        .avs_address(avs_address),
        .avs_byteenable(avs_byteenable),
        .avs_read(avs_read),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .avs_waitrequest(avs_waitrequest),
        .SRAM_ADDR(sram_addr),
        .SRAM_DQ(sram_dq),
        .SRAM_CE_N(sram_ce_n),
        .SRAM_OE_N(sram_oe_n),
        .SRAM_WE_N(sram_we_n),
        .SRAM_BE_N(sram_be_n)
    );

    always #5 clk = ~clk;

    // ---------------- SRAM pin model ----------------
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    assign sram_dq = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : {DW{1'bz}};

    // Memory contents are owned by this one process: preload, then latch writes mid-cycle.
    initial begin
        for (int i = 0; i < (1 << AW); i++) sram_mem[i] = '0;
        sram_mem[18'h00123] = 16'hA5C3;
        forever begin
            @(negedge clk);
            if (!sram_ce_n && !sram_we_n) begin
                for (int l = 0; l < 2; l++)
                    if (!sram_be_n[l]) sram_mem[sram_addr][8*l +: 8] = sram_dq[8*l +: 8];
            end
        end
    end

    // ---------------- monitors ----------------
    int  rdv_count = 0;
    int  contention_cnt = 0;
    logic prev_oe_low = 1'b0;
    int  cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (avs_readdatavalid) rdv_count <= rdv_count + 1;

    // Bus-fight watch: SRAM output enabled together with WE, or controller drive
    // starting on the cycle right after the SRAM was driving.
    always @(negedge clk) begin
        if (rst_n && !sram_oe_n && !sram_we_n) begin
            $display("FAIL dq_contention: OE_N and WE_N both low at t=%0t", $time);
            contention_cnt <= contention_cnt + 1;
        end else if (rst_n && !sram_ce_n && sram_oe_n && prev_oe_low) begin
            $display("FAIL dq_contention: controller drive right after SRAM drive at t=%0t", $time);
            contention_cnt <= contention_cnt + 1;
        end
        prev_oe_low <= !sram_oe_n;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model and checking ----------------
    int n_cmp = 0;
    int n_fail = 0;
    int exp_rdv_total = 0;
    bit prev_rd = 1'b0;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One Avalon transaction; returns at the falling edge of the first non-busy cycle.
    task automatic do_op(input bit w, input logic [AW-1:0] a, input logic [1:0] be,
                         input logic [DW-1:0] d, output logic [DW-1:0] rd);
        int n;
        int exp_busy;
        logic [DW-1:0] mask;
        avs_address    = a;
        avs_byteenable = be;
        avs_writedata  = d;
        avs_write      = w;
        avs_read       = !w;
        n = 0;
        while (avs_waitrequest && n < 50) begin @(negedge clk); n++; end
        check("accept_in_budget", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        avs_read  = 1'b0;
        avs_write = 1'b0;
        exp_busy = w ? (WW + 2 + (prev_rd ? TA : 0)) : (RW + 1);
        n = 0;
        @(negedge clk);
        while (avs_waitrequest && n < 100) begin n++; @(negedge clk); end
        check($sformatf("%s_busy_cycles a=%0h", w ? "wr" : "rd", a), n, exp_busy);
        rd = avs_readdata;
        if (!w) begin
            check($sformatf("rd_valid a=%0h", a), avs_readdatavalid, 1);
            check($sformatf("rd_data a=%0h", a), avs_readdata, ref_mem[a]);
            exp_rdv_total++;
            prev_rd = 1'b1;
        end else begin
            mask = {{8{be[1]}}, {8{be[0]}}};
            ref_mem[a] = (ref_mem[a] & ~mask) | (d & mask);
            $display("write a=%05h be=%b d=%04h", a, be, d);
            prev_rd = 1'b0;
        end
        if (!w) $display("read  a=%05h d=%04h", a, rd);
    endtask

    typedef struct {
        bit            w;
        logic [AW-1:0] a;
        logic [1:0]    be;
        logic [DW-1:0] d;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [DW-1:0] rd;
        int snap;
        int last_cyc;

        vecs[0]  = '{1'b0, 18'h3FFFF, 2'b11, 16'h0000, 16'h1234};
        vecs[1]  = '{1'b0, 18'h00055, 2'b11, 16'h0000, 16'hCAFE};
        vecs[2]  = '{1'b1, 18'h00010, 2'b10, 16'hBEEF, 16'h0000};
        vecs[3]  = '{1'b0, 18'h00010, 2'b11, 16'h0000, 16'hBE00};
        vecs[4]  = '{1'b1, 18'h00010, 2'b00, 16'h1111, 16'h0000};
        vecs[5]  = '{1'b0, 18'h00010, 2'b11, 16'h0000, 16'hBE00};
        vecs[6]  = '{1'b1, 18'h00010, 2'b01, 16'h00CD, 16'h0000};
        vecs[7]  = '{1'b0, 18'h00010, 2'b11, 16'h0000, 16'hBECD};
        vecs[8]  = '{1'b0, 18'h00123, 2'b11, 16'h0000, 16'hA5C3};
        vecs[9]  = '{1'b1, 18'h00123, 2'b11, 16'h0F0F, 16'h0000};
        vecs[10] = '{1'b0, 18'h00123, 2'b11, 16'h0000, 16'h0F0F};

        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
        ref_mem[18'h00123] = 16'hA5C3;

        rst_n = 1'b0;
        avs_address = '0; avs_byteenable = '0; avs_read = 1'b0;
        avs_write = 1'b0; avs_writedata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_waitrequest", avs_waitrequest, 1);
        check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        check("rst_be_n", sram_be_n, 2'b11);
        check("rst_addr", sram_addr, 0);
        check("rst_rdv", avs_readdatavalid, 0);
        check("rst_rdata", avs_readdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_waitrequest", avs_waitrequest, 0);
        $display("reset released");

        // Write waveform: WE low WW+1 cycles, one hold cycle with data still on DQ
        avs_write = 1'b1; avs_address = 18'h3FFFF; avs_writedata = 16'h1234; avs_byteenable = 2'b11;
        @(posedge clk); #1 avs_write = 1'b0;
        for (int c = 1; c <= WW + 3; c++) begin
            @(negedge clk);
            if (c <= WW + 1) begin
                check($sformatf("wr_wave_c%0d_pins", c),
                      {sram_ce_n, sram_oe_n, sram_we_n, avs_waitrequest}, 4'b0101);
                check($sformatf("wr_wave_c%0d_dq", c), sram_dq, 16'h1234);
                check($sformatf("wr_wave_c%0d_addr", c), sram_addr, 18'h3FFFF);
                check($sformatf("wr_wave_c%0d_be_n", c), sram_be_n, 2'b00);
            end else if (c == WW + 2) begin
                check("wr_wave_hold_pins", {sram_ce_n, sram_oe_n, sram_we_n, avs_waitrequest}, 4'b0111);
                check("wr_wave_hold_dq", sram_dq, 16'h1234);
                check("wr_wave_hold_addr", sram_addr, 18'h3FFFF);
            end else begin
                check("wr_wave_idle_pins", {sram_ce_n, sram_oe_n, sram_we_n, avs_waitrequest}, 4'b1110);
            end
        end
        ref_mem[18'h3FFFF] = 16'h1234;
        prev_rd = 1'b0;
        $display("write a=3ffff be=11 d=1234 (waveform)");

        // Read latency: strobes low for RW+1 cycles, data valid in the next cycle
        avs_read = 1'b1; avs_address = 18'h00123;
        @(posedge clk); #1 avs_read = 1'b0;
        for (int c = 1; c <= RW + 2; c++) begin
            @(negedge clk);
            if (c <= RW + 1) begin
                check($sformatf("rd_lat_c%0d_pins", c),
                      {sram_ce_n, sram_oe_n, sram_we_n, avs_waitrequest}, 4'b0011);
                check($sformatf("rd_lat_c%0d_rdv", c), avs_readdatavalid, 0);
                check($sformatf("rd_lat_c%0d_addr", c), sram_addr, 18'h00123);
                check($sformatf("rd_lat_c%0d_be_n", c), sram_be_n, 2'b00);
            end else begin
                check("rd_lat_rdv", avs_readdatavalid, 1);
                check("rd_lat_data", avs_readdata, 16'hA5C3);
                check("rd_lat_pins", {sram_ce_n, sram_oe_n, sram_we_n, avs_waitrequest}, 4'b1110);
            end
        end
        exp_rdv_total++;
        $display("read  a=00123 d=%04h (latency)", avs_readdata);

        // Turnaround: write issued right after the read gets TA idle cycles first
        avs_write = 1'b1; avs_address = 18'h00055; avs_writedata = 16'hCAFE; avs_byteenable = 2'b11;
        @(posedge clk); #1 avs_write = 1'b0;
        for (int c = 1; c <= TA + WW + 3; c++) begin
            @(negedge clk);
            if (c <= TA) begin
                check($sformatf("turn_c%0d_pins", c),
                      {sram_ce_n, sram_oe_n, sram_we_n, avs_waitrequest}, 4'b1111);
                check($sformatf("turn_c%0d_addr", c), sram_addr, 18'h00055);
            end else if (c <= TA + WW + 1) begin
                check($sformatf("turn_wr_c%0d_pins", c),
                      {sram_ce_n, sram_oe_n, sram_we_n, avs_waitrequest}, 4'b0101);
            end else if (c == TA + WW + 2) begin
                check("turn_hold_pins", {sram_ce_n, sram_oe_n, sram_we_n, avs_waitrequest}, 4'b0111);
            end else begin
                check("turn_idle_pins", {sram_ce_n, sram_oe_n, sram_we_n, avs_waitrequest}, 4'b1110);
            end
        end
        ref_mem[18'h00055] = 16'hCAFE;
        prev_rd = 1'b0;
        $display("write a=00055 be=11 d=cafe (turnaround)");

        // Vector table
        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].w, vecs[i].a, vecs[i].be, vecs[i].d, rd);
            if (!vecs[i].w) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
        end

        // Throughput: back-to-back reads complete every RW+2 cycles, in order
        for (int i = 0; i < 8; i++) do_op(1'b1, 18'(18'h40 + i), 2'b11, 16'($urandom), rd);
        last_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            do_op(1'b0, 18'(18'h40 + i), 2'b11, 16'h0, rd);
            if (i > 0) check($sformatf("b2b_period_%0d", i), cyc - last_cyc, RW + 2);
            last_cyc = cyc;
        end

        // Reset in the second WR cycle: strobes release asynchronously
        do_op(1'b1, 18'h20001, 2'b11, 16'h5555, rd);
        avs_write = 1'b1; avs_address = 18'h20000; avs_writedata = 16'h7777; avs_byteenable = 2'b11;
        @(posedge clk); #1 avs_write = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("rstw_pins", {sram_ce_n, sram_oe_n, sram_we_n, avs_waitrequest}, 4'b1111);
        check("rstw_be_n", sram_be_n, 2'b11);
        check("rstw_addr", sram_addr, 0);
        ref_mem[18'h20000] = 16'h7777;
        prev_rd = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("rstw_wait_after", avs_waitrequest, 0);
        snap = rdv_count;
        repeat (5) @(negedge clk);
        check("rstw_no_rdv", rdv_count, snap);
        $display("reset during write");

        // Reset mid-read: the pending response is dropped
        avs_read = 1'b1; avs_address = 18'h00123;
        @(posedge clk); #1 avs_read = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rstr_pins", {sram_ce_n, sram_oe_n, sram_we_n, avs_waitrequest}, 4'b1111);
        @(negedge clk) rst_n = 1'b1;
        snap = rdv_count;
        repeat (6) @(negedge clk);
        check("rstr_no_rdv", rdv_count, snap);
        check("rstr_rdata", avs_readdata, 0);
        $display("reset during read");
        // Reset cleared the read history: no turnaround on this write
        do_op(1'b1, 18'h00001, 2'b11, 16'h0101, rd);

        // Randomized traffic against the reference memory
        for (int i = 0; i < 200; i++) begin
            do_op($urandom_range(0, 2) == 0, 18'($urandom_range(0, 31)),
                  2'($urandom_range(0, 3)), 16'($urandom), rd);
        end

        repeat (3) @(negedge clk);
        check("rdv_pulse_total", rdv_count, exp_rdv_total);
        check("dq_contention_events", contention_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
